// File: rtl/cpu_nios_sysid_pkg.sv
// Shared types and constants for the CPU_NIOS system-ID checker.
package cpu_nios_sysid_pkg;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        RD_ID = 5'b00010,
        RD_TS = 5'b00100,
        CMP   = 5'b01000,
        DONE  = 5'b10000
    } sysid_state_e;

    localparam logic        SYSID_ADDR_ID    = 1'b0;
    localparam logic        SYSID_ADDR_TS    = 1'b1;
    localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1478015793;

    function automatic logic is_read_state(input sysid_state_e s);
        return (s == RD_ID) || (s == RD_TS);
    endfunction

endpackage

// File: rtl/cpu_nios_sysid_timeout_ctr.sv
// Waitrequest stall counter; expire flags the stall cycle that would reach TIMEOUT_CYCLES.
module cpu_nios_sysid_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expire = count_en && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_nios_sysid_checker.sv
// Reads sysid ID/timestamp words over Avalon-MM and compares them with build-time values.
// Optional stall timeout enabled by defining SYSID_CHECK_TIMEOUT_EN.
module cpu_nios_sysid_checker
    import cpu_nios_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    sysid_state_e state, state_next;
    logic         stall_expire;
    logic         timeout_hit;
    logic         rerun;

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic ctr_clear;
    logic ctr_en;

    // Counter is held clear outside read states and on every accepted beat,
    // so each read phase starts counting from zero.
    assign ctr_clear = !is_read_state(state) || !avm_waitrequest;
    assign ctr_en    = is_read_state(state) && avm_waitrequest;

    cpu_nios_sysid_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clock    (clock),
        .reset    (reset),
        .clear    (ctr_clear),
        .count_en (ctr_en),
        .expire   (stall_expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout <= 1'b0;
        end else if (rerun) begin
            timeout <= 1'b0;
        end else if (timeout_hit) begin
            timeout <= 1'b1;
        end
    end
`else
    assign stall_expire = 1'b0;
    assign timeout      = 1'b0;
`endif

    assign timeout_hit = is_read_state(state) && avm_waitrequest && stall_expire;
    assign rerun       = (state_next == RD_ID) && (state != RD_ID);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = RD_ID;
            RD_ID: begin
                if (!avm_waitrequest)  state_next = RD_TS;
                else if (stall_expire) state_next = DONE;
            end
            RD_TS: begin
                if (!avm_waitrequest)  state_next = CMP;
                else if (stall_expire) state_next = DONE;
            end
            CMP:   state_next = DONE;
            DONE:  if (start) state_next = RD_ID;
            default: state_next = IDLE;
        endcase
    end

    // Bus and status outputs are registered from the next state so they
    // change on the same edge as the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            captured_id <= '0;
            captured_ts <= '0;
        end else begin
            state       <= state_next;
            avm_read    <= is_read_state(state_next);
            avm_address <= (state_next == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
            busy        <= is_read_state(state_next) || (state_next == CMP);
            done        <= (state_next == DONE);

            if ((state == RD_ID) && !avm_waitrequest) captured_id <= avm_readdata;
            if ((state == RD_TS) && !avm_waitrequest) captured_ts <= avm_readdata;

            if (rerun || timeout_hit) begin
                pass        <= 1'b0;
                id_mismatch <= 1'b0;
                ts_mismatch <= 1'b0;
            end else if (state == CMP) begin
                id_mismatch <= (captured_id != EXPECTED_ID);
                ts_mismatch <= (captured_ts != EXPECTED_TS);
                pass        <= (captured_id == EXPECTED_ID) && (captured_ts == EXPECTED_TS);
            end
        end
    end

endmodule

// File: tb/tb_cpu_nios_sysid_checker.sv
// Randomized self-checking bench for cpu_nios_sysid_checker; the bench plays the sysid slave.
module tb_cpu_nios_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1478015793;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] captured_id, captured_ts;

    logic [31:0] slave_id = EXP_ID;
    logic [31:0] slave_ts = EXP_TS;
    assign avm_readdata = avm_address ? slave_ts : slave_id;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle outputs, produced by the run timeline below
    bit          chk_en = 1'b0;
    logic        e_read, e_addr, e_busy, e_done, e_pass, e_idm, e_tsm;
    logic [31:0] cap_id_m = '0;
    logic [31:0] cap_ts_m = '0;

    cpu_nios_sysid_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_mismatch     (id_mismatch),
        .ts_mismatch     (ts_mismatch),
        .timeout         (timeout),
        .captured_id     (captured_id),
        .captured_ts     (captured_ts)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("avm_read", avm_read, e_read);
            if (e_read) chk("avm_address", avm_address, e_addr);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("pass", pass, e_pass);
            chk("id_mismatch", id_mismatch, e_idm);
            chk("ts_mismatch", ts_mismatch, e_tsm);
            chk("timeout", timeout, 0);
            chk("captured_id", captured_id, cap_id_m);
            chk("captured_ts", captured_ts, cap_ts_m);
        end
    end

    // One check run: s0/s1 stall cycles on the ID/TS reads. A run is s0+1
    // cycles of address 0, s1+1 of address 1, one compare cycle, then done.
    task automatic do_run(input int s0, input int s1, input logic [31:0] id_v,
                          input logic [31:0] ts_v, input bit use_start,
                          input bit noise, output int done_at);
        int ts_start, cmp_cyc;
        bit match;
        ts_start = s0 + 2;
        cmp_cyc  = s0 + s1 + 3;
        match    = (id_v == EXP_ID) && (ts_v == EXP_TS);
        slave_id = id_v;
        slave_ts = ts_v;
        done_at  = 0;
        if (use_start) start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int j = 1; j <= s0 + s1 + 6; j++) begin
            if (done === 1'b1 && done_at == 0) done_at = j;
            if (j == ts_start) cap_id_m = id_v;
            if (j == cmp_cyc)  cap_ts_m = ts_v;
            e_read = (j < cmp_cyc);
            e_addr = (j >= ts_start);
            e_busy = (j <= cmp_cyc);
            e_done = (j > cmp_cyc);
            e_pass = e_done && match;
            e_idm  = e_done && (id_v != EXP_ID);
            e_tsm  = e_done && (ts_v != EXP_TS);
            avm_waitrequest = (j <= s0) || (j >= ts_start && j <= s0 + s1 + 1);
            chk_en = 1'b1;
            if (noise && j <= cmp_cyc && (j == ts_start || $urandom_range(0, 2) == 0))
                start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
        end
        avm_waitrequest = 1'b0;
    endtask

    initial begin
        int d;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_read", avm_read, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_cap_id", captured_id, 0);
        chk("rst_cap_ts", captured_ts, 0);
        reset = 1'b0;

        // Automatic check after reset, no stalls
        do_run(0, 0, EXP_ID, EXP_TS, 0, 0, d);
        chk("lit_done_cycle_nostall", d, 4);
        chk("lit_pass", pass, 1);
        chk("lit_idm0", id_mismatch, 0);
        chk("lit_tsm0", ts_mismatch, 0);

        do_run(0, 0, 32'h0000_0001, EXP_TS, 1, 0, d);
        chk("lit_idm1", id_mismatch, 1);
        chk("lit_pass_idm", pass, 0);
        chk("lit_cap_id1", captured_id, 32'h0000_0001);

        do_run(3, 3, EXP_ID, EXP_TS, 1, 0, d);
        chk("lit_done_cycle_stall3", d, 10);

        // Changed timestamp, with start pulsed during RD_TS
        do_run(1, 2, EXP_ID, 32'd5, 1, 1, d);
        chk("lit_tsm5", ts_mismatch, 1);
        chk("lit_cap_ts5", captured_ts, 32'd5);
        chk("lit_done_cycle_noise", d, 7);

        repeat (10) begin
            int s0, s1;
            logic [31:0] iv, tv;
            s0 = $urandom_range(0, 3);
            s1 = $urandom_range(0, 3);
            iv = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
            tv = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
            do_run(s0, s1, iv, tv, 1, $urandom_range(0, 1), d);
            chk("done_cycle_rand", d, s0 + s1 + 4);
        end

        // Reset in the middle of the timestamp read
        chk_en = 1'b0;
        slave_id = 32'h1234_5678;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        avm_waitrequest = 1'b0;
        @(posedge clock); #1;
        avm_waitrequest = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("midrst_read", avm_read, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cap_id", captured_id, 0);
        cap_id_m = '0;
        cap_ts_m = '0;
        avm_waitrequest = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        do_run(0, 1, EXP_ID, EXP_TS, 0, 0, d);
        chk("midrst_rerun_done", d, 5);
        chk("midrst_rerun_pass", pass, 1);

`ifdef SYSID_CHECK_TIMEOUT_EN
        chk_en = 1'b0;
        avm_waitrequest = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            chk("to_read_stall", avm_read, 1);
            @(posedge clock); #1;
        end
        chk("to_read_dropped", avm_read, 0);
        chk("to_timeout", timeout, 1);
        chk("to_done", done, 1);
        chk("to_pass", pass, 0);
        avm_waitrequest = 1'b0;
        do_run(0, 0, EXP_ID, EXP_TS, 1, 0, d);
        chk("to_rerun_pass", pass, 1);
`endif

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
